// File: rtl/bitstream_packer.sv
// Variable-length code packer: concatenates 0..MAXLEN-bit codes into OW-bit words.
// Optional bit/word counters are enabled by defining BITSTREAM_PACKER_CNT_EN.
module bitstream_packer #(
  parameter int unsigned OW        = 32,
  parameter int unsigned MAXLEN    = 32,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ivalid,
  output logic                          iready,
  input  logic [$clog2(MAXLEN+1)-1:0]   ilength,
  input  logic [MAXLEN-1:0]             idata,
  input  logic                          iflush,
  output logic [2:0]                    rest,
  output logic                          ovalid,
  input  logic                          oready,
  output logic [OW-1:0]                 odata,
  output logic                          olast
`ifdef BITSTREAM_PACKER_CNT_EN
  ,
  output logic [31:0]                   bitcnt,
  output logic [31:0]                   wordcnt
`endif
);

  localparam int unsigned LW = $clog2(MAXLEN + 1);
  localparam int unsigned FW = $clog2(OW);
  localparam int unsigned SW = FW + 1;
  localparam int unsigned HW = FW + 2;
  localparam int unsigned DW = 2 * OW;

  typedef enum logic {RUN = 1'b0, FLUSH_PEND = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   acc, acc_nxt;
  logic [FW-1:0]   fill, fill_nxt;

  logic [LW-1:0]   len_eff;
  logic [MAXLEN-1:0] code_m;
  logic [SW-1:0]   new_fill, rem_fill;
  logic [HW-1:0]   msb_sh;
  logic [DW-1:0]   comb_v;
  logic [OW-1:0]   first_part, second_part;
  logic            word_done, out_free, accept;
  logic            load, load_last;
  logic [OW-1:0]   load_data;

  assign len_eff  = (ilength > LW'(MAXLEN)) ? LW'(MAXLEN) : ilength;
  assign out_free = !ovalid || oready;
  assign accept   = ivalid && (state == RUN) && out_free;
  assign rest     = 3'(3'd0 - fill[2:0]);

  // Drop code bits at and above the effective length
  always_comb begin
    code_m = '0;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      if (i < int'(len_eff)) code_m[i] = idata[i];
    end
  end

  assign new_fill  = SW'(fill) + SW'(len_eff);
  assign word_done = (new_fill >= SW'(OW));
  assign rem_fill  = word_done ? (new_fill - SW'(OW)) : new_fill;
  assign msb_sh    = HW'(DW) - HW'(fill) - HW'(len_eff);

  // Stream-ordered append: the first OW stream bits land in first_part
  always_comb begin
    if (MSB_FIRST != 0) begin
      comb_v      = {acc, {OW{1'b0}}} | (DW'(code_m) << msb_sh);
      first_part  = comb_v[DW-1:OW];
      second_part = comb_v[OW-1:0];
    end else begin
      comb_v      = {{OW{1'b0}}, acc} | (DW'(code_m) << fill);
      first_part  = comb_v[OW-1:0];
      second_part = comb_v[DW-1:OW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:        if (accept && iflush && word_done && (rem_fill != '0)) state_nxt = FLUSH_PEND;
      FLUSH_PEND: if (out_free) state_nxt = RUN;
      default:    state_nxt = RUN;
    endcase
  end

  // Handshake, word-load and accumulator update decisions
  always_comb begin
    iready    = (state == RUN) && out_free;
    load      = 1'b0;
    load_data = first_part;
    load_last = 1'b0;
    acc_nxt   = acc;
    fill_nxt  = fill;
    case (state)
      RUN: begin
        if (accept) begin
          if (word_done) begin
            load    = 1'b1;
            acc_nxt = second_part;
          end else begin
            acc_nxt = first_part;
          end
          fill_nxt = FW'(rem_fill);
          if (iflush) begin
            if (word_done) begin
              load_last = (rem_fill == '0);
            end else if (rem_fill != '0) begin
              load      = 1'b1;
              load_last = 1'b1;
            end
            if (!(word_done && (rem_fill != '0))) begin
              acc_nxt  = '0;
              fill_nxt = '0;
            end
          end
        end
      end
      FLUSH_PEND: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = acc;
          load_last = 1'b1;
          acc_nxt   = '0;
          fill_nxt  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      fill   <= '0;
      ovalid <= 1'b0;
      odata  <= '0;
      olast  <= 1'b0;
    end else begin
      acc  <= acc_nxt;
      fill <= fill_nxt;
      if (load) begin
        ovalid <= 1'b1;
        odata  <= load_data;
        olast  <= load_last;
      end else if (ovalid && oready) begin
        ovalid <= 1'b0;
        odata  <= '0;
        olast  <= 1'b0;
      end
    end
  end

`ifdef BITSTREAM_PACKER_CNT_EN
  // Code bits accepted (padding excluded) and words handed downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt  <= '0;
      wordcnt <= '0;
    end else begin
      if (accept)          bitcnt  <= bitcnt + 32'(len_eff);
      if (ovalid && oready) wordcnt <= wordcnt + 32'd1;
    end
  end
`endif

endmodule
